// File: rtl/collision_detector.sv
// 8x8 snake-board collision checker with registered result, hit counter.
// Define COLLIDE_STICKY_EN to build the sticky game_over flag.
module collision_detector #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             check,
   input  logic [7:0]       row1,
   input  logic [7:0]       row2,
   input  logic [7:0]       row3,
   input  logic [7:0]       row4,
   input  logic [7:0]       row5,
   input  logic [7:0]       row6,
   input  logic [7:0]       row7,
   input  logic [7:0]       row8,
   input  logic [2:0]       coordinate_x,
   input  logic [2:0]       coordinate_y,
   output logic             collide,
   output logic             collide_valid,
   output logic [CNT_W-1:0] hit_count,
   output logic             game_over
);

   logic [7:0]       row_sel;
   logic             hit;
   logic             collide_d, collide_q;
   logic             valid_d, valid_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      row_sel = row1;
      unique case (coordinate_y)
         3'd0: row_sel = row1;
         3'd1: row_sel = row2;
         3'd2: row_sel = row3;
         3'd3: row_sel = row4;
         3'd4: row_sel = row5;
         3'd5: row_sel = row6;
         3'd6: row_sel = row7;
         3'd7: row_sel = row8;
      endcase
   end

   // x=0 is the leftmost LED, which is the row MSB
   assign hit = row_sel[3'd7 - coordinate_x];

   always_comb begin
      collide_d = collide_q;
      valid_d   = 1'b0;
      cnt_d     = cnt_q;
      if (clear) begin
         collide_d = 1'b0;
         cnt_d     = '0;
      end else if (check) begin
         collide_d = hit;
         valid_d   = 1'b1;
         if (hit && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         collide_q <= 1'b0;
         valid_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         collide_q <= collide_d;
         valid_q   <= valid_d;
         cnt_q     <= cnt_d;
      end
   end

`ifdef COLLIDE_STICKY_EN
   logic go_d, go_q;

   always_comb begin
      go_d = go_q;
      if (clear)
         go_d = 1'b0;
      else if (check && hit)
         go_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         go_q <= 1'b0;
      else
         go_q <= go_d;
   end

   assign game_over = go_q;
`else
   assign game_over = 1'b0;
`endif

   assign collide       = collide_q;
   assign collide_valid = valid_q;
   assign hit_count     = cnt_q;

endmodule

// File: tb/tb_collision_detector.sv
// Randomized bench for collision_detector against a board-level model.
// Small counter width so saturation is reached often.
module tb_collision_detector;

   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic          check;
   logic [7:0]    rows [8];
   logic [2:0]    coordinate_x;
   logic [2:0]    coordinate_y;
   logic          collide;
   logic          collide_valid;
   logic [CW-1:0] hit_count;
   logic          game_over;

   int total = 0;
   int bad   = 0;

   int m_collide;
   int m_valid;
   int m_cnt;
   int m_go;

   collision_detector #(.CNT_W(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .check        (check),
      .row1         (rows[0]),
      .row2         (rows[1]),
      .row3         (rows[2]),
      .row4         (rows[3]),
      .row5         (rows[4]),
      .row6         (rows[5]),
      .row7         (rows[6]),
      .row8         (rows[7]),
      .coordinate_x (coordinate_x),
      .coordinate_y (coordinate_y),
      .collide      (collide),
      .collide_valid(collide_valid),
      .hit_count    (hit_count),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   task automatic expect_eq(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_go();
`ifdef COLLIDE_STICKY_EN
      return m_go;
`else
      return 0;
`endif
   endfunction

   task automatic compare_all(input string tag);
      expect_eq({tag, ".collide"}, int'(collide), m_collide);
      expect_eq({tag, ".valid"}, int'(collide_valid), m_valid);
      expect_eq({tag, ".count"}, int'(hit_count), m_cnt);
      expect_eq({tag, ".game_over"}, int'(game_over), exp_go());
   endtask

   task automatic clear_board();
      for (int i = 0; i < 8; i++) rows[i] = 8'h00;
   endtask

   // One clock: drive, wait for edge, update the model, compare.
   task automatic cyc(input string tag, input logic clr, input logic chk,
                      input int x, input int y);
      int h;
      clear        = clr;
      check        = chk;
      coordinate_x = 3'(x);
      coordinate_y = 3'(y);
      h = (rows[y] >> (7 - x)) & 1;
      @(posedge clk);
      #1;
      if (clr) begin
         m_collide = 0;
         m_valid   = 0;
         m_cnt     = 0;
         m_go      = 0;
      end else if (chk) begin
         m_collide = h;
         m_valid   = 1;
         if (h == 1) begin
            if (m_cnt < CMAX) m_cnt++;
            m_go = 1;
         end
      end else begin
         m_valid = 0;
      end
      compare_all(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      clear = 1'b0;
      check = 1'b0;
      coordinate_x = '0;
      coordinate_y = '0;
      clear_board();
      m_collide = 0;
      m_valid   = 0;
      m_cnt     = 0;
      m_go      = 0;
      #12;
      compare_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      rows[3] = 8'b0001_0000;
      cyc("hit", 1'b0, 1'b1, 3, 3);
      cyc("idle", 1'b0, 1'b0, 3, 3);
      rows[3] = 8'b0000_0010;
      cyc("miss", 1'b0, 1'b1, 3, 3);

      clear_board();
      rows[0] = 8'h80;
      cyc("corner00", 1'b0, 1'b1, 0, 0);
      clear_board();
      rows[7] = 8'h01;
      cyc("corner77", 1'b0, 1'b1, 7, 7);
      cyc("corner07", 1'b0, 1'b1, 0, 7);
      cyc("sticky", 1'b0, 1'b0, 0, 7);

      for (int i = 0; i < 5; i++) cyc("sat", 1'b0, 1'b1, 7, 7);
      cyc("clear", 1'b1, 1'b1, 7, 7);

      cyc("rehit", 1'b0, 1'b1, 7, 7);
      cyc("rehit2", 1'b0, 1'b1, 7, 7);
      rst_n = 1'b0;
      #1;
      m_collide = 0;
      m_valid   = 0;
      m_cnt     = 0;
      m_go      = 0;
      compare_all("async_rst");
      #2;
      rst_n = 1'b1;
      @(negedge clk);

      for (int n = 0; n < 400; n++) begin
         int r;
         for (int i = 0; i < 8; i++) rows[i] = 8'($urandom);
         r = int'($urandom_range(0, 99));
         cyc("rand", r < 5, r < 80,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
